// File: rtl/rgbw_mult_sched.sv
// Frame scheduler that scales four RGBW channel levels by a global intensity
// through a shared 8x8 multiplier, committing all four duties atomically.
module rgbw_mult_sched #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [7:0]  w,
    input  logic [7:0]  intensity,
    output logic        mult_ld,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic        mult_rdy,
    input  logic [15:0] mult_result,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic [7:0]  duty_w,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_WAIT_LOW = 3'd4,
        ST_COMMIT   = 3'd5
    } state_t;

    // Last wait-counter value before the next waiting cycle would reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Round the 8.8 product to the nearest integer, clamping at full scale.
    function automatic logic [7:0] round_sat(input logic [15:0] prod);
        logic [8:0] sum;
        sum = {1'b0, prod[15:8]} + {8'd0, prod[7]};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  ch_r, ch_s;
    logic [7:0]  chan_r [4];
    logic [7:0]  chan_s [4];
    logic [7:0]  stage_r [4];
    logic [7:0]  stage_s [4];
    logic [7:0]  duty_arr_r [4];
    logic [7:0]  duty_arr_s [4];
    logic [7:0]  inten_r, inten_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic        err_r, err_s;
    logic        abort_r, abort_s;
    logic        mult_ld_r, mult_ld_s;
    logic [7:0]  mult_a_r, mult_a_s;
    logic [7:0]  mult_b_r, mult_b_s;
    logic        done_r, done_s;
    logic        busy_r, busy_s;
    logic        timeout_s;
    logic        unused_lsb_s;

    assign unused_lsb_s = ^mult_result[6:0];
    assign timeout_s    = (wait_cnt_r == WAIT_LAST);

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s    = state_r;
        ch_s       = ch_r;
        chan_s     = chan_r;
        stage_s    = stage_r;
        duty_arr_s = duty_arr_r;
        inten_s    = inten_r;
        wait_cnt_s = wait_cnt_r;
        err_s      = err_r;
        abort_s    = abort_r;
        mult_a_s   = mult_a_r;
        mult_b_s   = mult_b_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // After an abort, a still-high rdy would make the next load edge illegal.
                if (start && !(abort_r && mult_rdy)) begin
                    chan_s  = '{r, g, b, w};
                    inten_s = intensity;
                    err_s   = 1'b0;
                    abort_s = 1'b0;
                    ch_s    = 2'd0;
                    if (intensity == 8'd0) begin
                        stage_s = '{default: 8'd0};
                        state_s = ST_COMMIT;
                    end else if (intensity == 8'hFF) begin
                        stage_s = '{r, g, b, w};
                        state_s = ST_COMMIT;
                    end else begin
                        mult_a_s = r;
                        mult_b_s = intensity;
                        state_s  = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                wait_cnt_s = 8'd0;
                state_s    = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (mult_rdy) begin
                    state_s = ST_CAPTURE;
                end else if (timeout_s) begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                    stage_s    = '{default: 8'd0};
                    err_s      = 1'b1;
                    abort_s    = 1'b1;
                    ch_s       = 2'd0;
                    state_s    = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_CAPTURE: begin
                stage_s[ch_r] = round_sat(mult_result);
                wait_cnt_s    = 8'd0;
                state_s       = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!mult_rdy) begin
                    if (ch_r == 2'd3) begin
                        state_s = ST_COMMIT;
                    end else begin
                        ch_s     = ch_r + 2'd1;
                        mult_a_s = chan_r[ch_r + 2'd1];
                        mult_b_s = inten_r;
                        state_s  = ST_LOAD;
                    end
                end else if (timeout_s) begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                    stage_s    = '{default: 8'd0};
                    err_s      = 1'b1;
                    abort_s    = 1'b1;
                    ch_s       = 2'd0;
                    state_s    = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_COMMIT: begin
                duty_arr_s = stage_r;
                done_s     = 1'b1;
                ch_s       = 2'd0;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Load request tracks the destination state so it is a clean register output.
        mult_ld_s = (state_s == ST_LOAD) || (state_s == ST_WAIT_RDY);
        busy_s    = (state_s != ST_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ch_r       <= 2'd0;
            chan_r     <= '{default: 8'd0};
            stage_r    <= '{default: 8'd0};
            duty_arr_r <= '{default: 8'd0};
            inten_r    <= 8'd0;
            wait_cnt_r <= 8'd0;
            err_r      <= 1'b0;
            abort_r    <= 1'b0;
            mult_ld_r  <= 1'b0;
            mult_a_r   <= 8'd0;
            mult_b_r   <= 8'd0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ch_r       <= ch_s;
            chan_r     <= chan_s;
            stage_r    <= stage_s;
            duty_arr_r <= duty_arr_s;
            inten_r    <= inten_s;
            wait_cnt_r <= wait_cnt_s;
            err_r      <= err_s;
            abort_r    <= abort_s;
            mult_ld_r  <= mult_ld_s;
            mult_a_r   <= mult_a_s;
            mult_b_r   <= mult_b_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
        end
    end

    assign mult_ld = mult_ld_r;
    assign mult_a  = mult_a_r;
    assign mult_b  = mult_b_r;
    assign duty_r  = duty_arr_r[0];
    assign duty_g  = duty_arr_r[1];
    assign duty_b  = duty_arr_r[2];
    assign duty_w  = duty_arr_r[3];
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_rgbw_mult_sched.sv
// Self-checking bench for rgbw_mult_sched: vector table, multiplier model with
// 3-cycle ready, and a scoreboard of expected committed duties.
module tb_rgbw_mult_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  r, g, b, w, intensity;
    logic        mult_ld;
    logic [7:0]  mult_a, mult_b;
    logic        mult_rdy;
    logic [15:0] mult_result;
    logic [7:0]  duty_r, duty_g, duty_b, duty_w;
    logic        busy, done, err;

    typedef struct packed {
        logic [7:0]  r, g, b, w, inten;
        logic [31:0] want;
        logic [7:0]  n_ld;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ld_edges = 0;
    int          done_cnt = 0;
    logic        prev_ld = 1'b0;
    logic [7:0]  prev_a = 8'd0, prev_b = 8'd0;
    logic [31:0] prev_duty = 32'd0;
    logic [31:0] last_want;
    logic        force_hi = 1'b0;
    logic        stuck = 1'b0;
    logic [1:0]  mcnt;

    rgbw_mult_sched #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start),
        .r(r), .g(g), .b(b), .w(w), .intensity(intensity),
        .mult_ld(mult_ld), .mult_a(mult_a), .mult_b(mult_b),
        .mult_rdy(mult_rdy), .mult_result(mult_result),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Multiplier model: result and rdy three cycles after load, rdy drops once load falls.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_rdy    <= 1'b0;
            mult_result <= 16'd0;
            mcnt        <= 2'd0;
        end else if (force_hi) begin
            mult_rdy <= 1'b1;
        end else if (stuck) begin
            mult_rdy <= 1'b0;
            mcnt     <= 2'd0;
        end else if (mult_ld && !mult_rdy) begin
            if (mcnt == 2'd2) begin
                mult_rdy    <= 1'b1;
                mult_result <= 16'(mult_a) * 16'(mult_b);
                mcnt        <= 2'd0;
            end else begin
                mcnt <= mcnt + 2'd1;
            end
        end else if (!mult_ld) begin
            mult_rdy <= 1'b0;
            mcnt     <= 2'd0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // One cycle: sample away from the edge and run the protocol/scoreboard monitors.
    task automatic tick();
        logic [31:0] d;
        @(negedge clk);
        #1;
        d = {duty_r, duty_g, duty_b, duty_w};
        if (mult_ld && !prev_ld) begin
            ld_edges++;
            chk("ld_rise_while_rdy", 64'(mult_rdy), 64'(1'b0));
        end else if (mult_ld && prev_ld) begin
            chk("operand_hold", 64'({mult_a, mult_b}), 64'({prev_a, prev_b}));
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
                chk("duty_commit", 64'(d), 64'(exp_q.pop_front()));
            end else begin
                chk("unexpected_done_queue", 64'(exp_q.size()), 64'(1));
            end
        end else begin
            chk("duty_hold", 64'(d), 64'(prev_duty));
        end
        prev_ld   = mult_ld;
        prev_a    = mult_a;
        prev_b    = mult_b;
        prev_duty = d;
    endtask

    task automatic set_inputs(input vec_t v);
        r = v.r; g = v.g; b = v.b; w = v.w; intensity = v.inten;
    endtask

    task automatic run_frame(input vec_t v, output int lat);
        int done_before;
        set_inputs(v);
        ld_edges    = 0;
        done_before = done_cnt;
        exp_q.push_back(v.want);
        start = 1'b1;
        tick();
        lat = 1;
        chk("busy_after_start", 64'(busy), 64'(1'b1));
        start = 1'b0;
        while (done_cnt == done_before && lat < 400) begin
            tick();
            lat++;
        end
        chk("frame_done_count", 64'(done_cnt - done_before), 64'(1));
        tick();
        tick();
        chk("single_done", 64'(done_cnt - done_before), 64'(1));
        chk("ld_edge_count", 64'(ld_edges), 64'(v.n_ld));
        chk("err_clear", 64'(err), 64'(1'b0));
        last_want = v.want;
    endtask

    initial begin
        int lat;
        int n;
        int done_before;
        vecs[0] = '{8'd255, 8'd128, 8'd1,   8'd0,   8'd128, 32'h80400100, 8'd4};
        vecs[1] = '{8'd10,  8'd20,  8'd30,  8'd40,  8'd0,   32'h00000000, 8'd0};
        vecs[2] = '{8'd7,   8'd200, 8'd255, 8'd33,  8'd255, 32'h07C8FF21, 8'd0};
        vecs[3] = '{8'd200, 8'd100, 8'd50,  8'd25,  8'd64,  32'h32190D06, 8'd4};
        vecs[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 32'hFDFDFDFD, 8'd4};
        vecs[5] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd200, 32'h01020203, 8'd4};

        reset = 1'b0;
        start = 1'b0;
        set_inputs(vecs[0]);
        tick();
        chk("reset_state", 64'({mult_ld, mult_a, mult_b, duty_r, duty_g, duty_b, duty_w, busy, done, err}), 64'(0));
        reset = 1'b1;

        // Table of frames; bypass intensities must commit within three cycles.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], lat);
            if (vecs[i].n_ld == 8'd0) begin
                chk("bypass_latency_le3", 64'(lat <= 3), 64'(1'b1));
            end
        end

        // Multiplier never answers on channel 1: expect abort after 15 waiting cycles.
        set_inputs(vecs[3]);
        ld_edges    = 0;
        done_before = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (ld_edges != 2 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_ch1_load", 64'(ld_edges), 64'(2));
        stuck = 1'b1;
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(16));
        chk("abort_outputs", 64'({mult_ld, busy}), 64'(0));
        chk("abort_no_done", 64'(done_cnt - done_before), 64'(0));
        chk("abort_duty_kept", 64'({duty_r, duty_g, duty_b, duty_w}), 64'(last_want));
        stuck = 1'b0;

        // With rdy still high after an abort, a start must be refused.
        force_hi = 1'b1;
        tick();
        tick();
        start = 1'b1;
        tick();
        tick();
        chk("start_gated_busy", 64'(busy), 64'(1'b0));
        chk("err_sticky", 64'(err), 64'(1'b1));
        start    = 1'b0;
        force_hi = 1'b0;
        tick();
        tick();
        run_frame(vecs[0], lat);

        // Start pulsed again mid-frame with new inputs must not disturb the frame.
        set_inputs(vecs[3]);
        ld_edges    = 0;
        done_before = done_cnt;
        exp_q.push_back(vecs[3].want);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        r = 8'd9; g = 8'd9; b = 8'd9; w = 8'd9; intensity = 8'd77;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == done_before && n < 400) begin
            tick();
            n++;
        end
        for (int i = 0; i < 6; i++) tick();
        chk("busy_start_one_done", 64'(done_cnt - done_before), 64'(1));
        chk("busy_start_ld_edges", 64'(ld_edges), 64'(4));
        chk("busy_start_idle", 64'(busy), 64'(1'b0));

        // Reset while waiting for channel 2 result clears everything without a clock.
        set_inputs(vecs[5]);
        ld_edges = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (ld_edges != 3 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("in_wait_rdy_ch2", 64'({mult_ld, busy, mult_a}), 64'({1'b1, 1'b1, 8'd3}));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_state", 64'({mult_ld, mult_a, mult_b, duty_r, duty_g, duty_b, duty_w, busy, done, err}), 64'(0));
        prev_ld   = 1'b0;
        prev_a    = 8'd0;
        prev_b    = 8'd0;
        prev_duty = 32'd0;
        tick();
        reset = 1'b1;
        run_frame(vecs[3], lat);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
